// File: rtl/nv_pg_seq_if.sv
// nv_pg_seq_if -- request/acknowledge and control bundle of the partition
// power-gating sequencer.
//   pg_off_req     : level request, 1 = partition off, 0 = on
//   pg_psw_ack     : switch-chain acknowledge, 1 = rail powered (already synchronised)
//   pg_psw_en      : power-switch enable
//   pg_iso_n       : isolation enable to the AND clamps, 0 = clamped
//   pg_clk_en      : partition clock enable
//   pg_ret_save    : one-cycle retention save pulse
//   pg_ret_restore : one-cycle retention restore pulse
//   pg_on          : partition fully on and released
//   pg_busy        : a sequence is in progress
//   pg_err         : acknowledge timeout seen in the current sequence
// master = power-management controller side, slave = sequencer side.
interface nv_pg_seq_if;
    logic pg_off_req;
    logic pg_psw_ack;
    logic pg_psw_en;
    logic pg_iso_n;
    logic pg_clk_en;
    logic pg_ret_save;
    logic pg_ret_restore;
    logic pg_on;
    logic pg_busy;
    logic pg_err;

    modport master (
        output pg_off_req, pg_psw_ack,
        input  pg_psw_en, pg_iso_n, pg_clk_en, pg_ret_save, pg_ret_restore,
               pg_on, pg_busy, pg_err
    );

    modport slave (
        input  pg_off_req, pg_psw_ack,
        output pg_psw_en, pg_iso_n, pg_clk_en, pg_ret_save, pg_ret_restore,
               pg_on, pg_busy, pg_err
    );
endinterface

// File: rtl/nv_pg_seq.sv
// nv_pg_seq -- power-gating sequencer for one switchable partition, living in
// the always-on domain next to the isolation clamps.
// Power-down: ON -> CLK_OFF -> ISO -> SAVE -> PSW_OFF -(ack=0)-> OFF.
// Power-up:   OFF -> PSW_ON -(ack=1)-> RESTORE -> ISO_REL -> CLK_ON -> ON.
// Ports:
//   nvdla_core_clk : always-on clock
//   nvdla_core_rst : asynchronous active-high reset, enters PSW_ON
//   pg             : nv_pg_seq_if slave modport (request, ack, controls, status)
// Parameters: STEP_DLY cycles per timed step, ACK_TMO cycles of ack wait
// before pg_err, CNT_W counter width.
module nv_pg_seq #(
    parameter int unsigned STEP_DLY = 4,
    parameter int unsigned ACK_TMO  = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic          nvdla_core_clk,
    input  logic          nvdla_core_rst,
    nv_pg_seq_if.slave    pg
);

    typedef enum logic [3:0] {
        ST_ON, ST_CLK_OFF, ST_ISO, ST_SAVE, ST_PSW_OFF,
        ST_OFF, ST_PSW_ON, ST_RESTORE, ST_ISO_REL, ST_CLK_ON
    } state_t;

    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DLY - 1);
    localparam logic [CNT_W-1:0] TMO_CNT   = CNT_W'(ACK_TMO);

    state_t            state_q, state_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt, cnt_sat;
    logic              err_q, err_nxt;
    logic              step_done;

    logic psw_en_q, iso_n_q, clk_en_q, save_q, restore_q, on_q, busy_q;

    // Wait counter stops at the timeout value; reaching it flags the error.
    assign cnt_sat   = (cnt_q == TMO_CNT) ? cnt_q : cnt_q + CNT_W'(1);
    assign step_done = (cnt_q == STEP_LAST);

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        err_nxt   = err_q;
        case (state_q)
            ST_ON: begin
                cnt_nxt = '0;
                if (pg.pg_off_req) state_nxt = ST_CLK_OFF;
            end
            ST_OFF: begin
                cnt_nxt = '0;
                if (!pg.pg_off_req) state_nxt = ST_PSW_ON;
            end
            ST_CLK_OFF, ST_ISO, ST_SAVE, ST_RESTORE, ST_ISO_REL, ST_CLK_ON: begin
                if (step_done) begin
                    cnt_nxt = '0;
                    case (state_q)
                        ST_CLK_OFF: state_nxt = ST_ISO;
                        ST_ISO:     state_nxt = ST_SAVE;
                        ST_SAVE:    state_nxt = ST_PSW_OFF;
                        ST_RESTORE: state_nxt = ST_ISO_REL;
                        ST_ISO_REL: state_nxt = ST_CLK_ON;
                        default:    state_nxt = ST_ON;
                    endcase
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            ST_PSW_OFF: begin
                if (!pg.pg_psw_ack) begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_sat;
                    if (cnt_sat == TMO_CNT) err_nxt = 1'b1;
                end
            end
            ST_PSW_ON: begin
                if (pg.pg_psw_ack) begin
                    state_nxt = ST_RESTORE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_sat;
                    if (cnt_sat == TMO_CNT) err_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_PSW_ON;
                cnt_nxt   = '0;
            end
        endcase
        if (state_nxt == ST_ON || state_nxt == ST_OFF) err_nxt = 1'b0;
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q   <= ST_PSW_ON;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            psw_en_q  <= 1'b1;
            iso_n_q   <= 1'b0;
            clk_en_q  <= 1'b0;
            save_q    <= 1'b0;
            restore_q <= 1'b0;
            on_q      <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            err_q     <= err_nxt;
            psw_en_q  <= !(state_nxt inside {ST_PSW_OFF, ST_OFF});
            iso_n_q   <= state_nxt inside {ST_ON, ST_CLK_OFF, ST_ISO_REL, ST_CLK_ON};
            clk_en_q  <= state_nxt inside {ST_ON, ST_CLK_ON};
            save_q    <= (state_nxt == ST_SAVE) && (state_q != ST_SAVE);
            restore_q <= (state_nxt == ST_RESTORE) && (state_q != ST_RESTORE);
            on_q      <= (state_nxt == ST_ON);
            busy_q    <= !(state_nxt inside {ST_ON, ST_OFF});
        end
    end

    assign pg.pg_psw_en      = psw_en_q;
    assign pg.pg_iso_n       = iso_n_q;
    assign pg.pg_clk_en      = clk_en_q;
    assign pg.pg_ret_save    = save_q;
    assign pg.pg_ret_restore = restore_q;
    assign pg.pg_on          = on_q;
    assign pg.pg_busy        = busy_q;
    assign pg.pg_err         = err_q;

endmodule

// File: tb/tb_nv_pg_seq.sv
// tb_nv_pg_seq -- directed bench for nv_pg_seq (STEP_DLY=4, ACK_TMO=8).
// Output vector layout: {psw_en, iso_n, clk_en, ret_save, ret_restore, on, busy, err}.
module tb_nv_pg_seq;
    localparam int N   = 4;
    localparam int TMO = 8;

    localparam logic [7:0] V_ON      = 8'b1110_0100;
    localparam logic [7:0] V_CLK_OFF = 8'b1100_0010;
    localparam logic [7:0] V_MID     = 8'b1000_0010; // ISO, SAVE, PSW_ON, RESTORE, reset
    localparam logic [7:0] V_PSW_OFF = 8'b0000_0010;
    localparam logic [7:0] V_OFF     = 8'b0000_0000;
    localparam logic [7:0] V_ISO_REL = 8'b1100_0010;
    localparam logic [7:0] V_CLK_ON  = 8'b1110_0010;
    localparam logic [7:0] P_SAVE    = 8'b0001_0000;
    localparam logic [7:0] P_REST    = 8'b0000_1000;
    localparam logic [7:0] P_ERR     = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    nv_pg_seq_if pg_if ();

    nv_pg_seq #(.STEP_DLY(N), .ACK_TMO(TMO), .CNT_W(16)) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .pg             (pg_if.slave)
    );

    function automatic logic [7:0] obs();
        return {pg_if.pg_psw_en, pg_if.pg_iso_n, pg_if.pg_clk_en, pg_if.pg_ret_save,
                pg_if.pg_ret_restore, pg_if.pg_on, pg_if.pg_busy, pg_if.pg_err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        rst = 1'b1;
        pg_if.pg_off_req = 1'b0;
        pg_if.pg_psw_ack = 1'b1;
        step();
        n_cmp++;
        if (obs() !== V_MID) begin
            n_bad++;
            $display("FAIL reset_values got=%b exp=%b", obs(), V_MID);
        end
        rst = 1'b0;
        for (int k = 1; k <= 3*N + 2; k++) begin
            step();
            if (k <= N)        exp = V_MID | ((k == 1) ? P_REST : 8'h00);
            else if (k <= 2*N) exp = V_ISO_REL;
            else if (k <= 3*N) exp = V_CLK_ON;
            else               exp = V_ON;
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL reset_powerup k=%0d got=%b exp=%b", k, obs(), exp);
            end
        end
    endtask

    task automatic test_power_down();
        logic [7:0] exp;
        pg_if.pg_off_req = 1'b1;
        for (int k = 1; k <= 3*N + 6; k++) begin
            step();
            if (k <= N)          exp = V_CLK_OFF;
            else if (k <= 2*N)   exp = V_MID;
            else if (k <= 3*N)   exp = V_MID | ((k == 2*N + 1) ? P_SAVE : 8'h00);
            else if (k <= 3*N+3) exp = V_PSW_OFF;
            else                 exp = V_OFF;
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL power_down k=%0d got=%b exp=%b", k, obs(), exp);
            end
            if (k == 3*N + 3) pg_if.pg_psw_ack = 1'b0;
        end
    endtask

    task automatic test_power_up();
        logic [7:0] exp;
        pg_if.pg_off_req = 1'b0;
        for (int k = 1; k <= 3*N + 4; k++) begin
            step();
            if (k <= 2)            exp = V_MID;
            else if (k <= 2 + N)   exp = V_MID | ((k == 3) ? P_REST : 8'h00);
            else if (k <= 2 + 2*N) exp = V_ISO_REL;
            else if (k <= 2 + 3*N) exp = V_CLK_ON;
            else                   exp = V_ON;
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL power_up k=%0d got=%b exp=%b", k, obs(), exp);
            end
            if (k == 2) pg_if.pg_psw_ack = 1'b1;
        end
    endtask

    task automatic test_reverse_in_save();
        logic [7:0] exp;
        int n_save = 0;
        int n_rest = 0;
        pg_if.pg_off_req = 1'b1;
        for (int k = 1; k <= 6*N + 5; k++) begin
            step();
            if (k <= N)            exp = V_CLK_OFF;
            else if (k <= 2*N)     exp = V_MID;
            else if (k <= 3*N)     exp = V_MID | ((k == 2*N + 1) ? P_SAVE : 8'h00);
            else if (k == 3*N + 1) exp = V_PSW_OFF;
            else if (k == 3*N + 2) exp = V_OFF;
            else if (k == 3*N + 3) exp = V_MID;
            else if (k <= 4*N + 3) exp = V_MID | ((k == 3*N + 4) ? P_REST : 8'h00);
            else if (k <= 5*N + 3) exp = V_ISO_REL;
            else if (k <= 6*N + 3) exp = V_CLK_ON;
            else                   exp = V_ON;
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL reverse k=%0d got=%b exp=%b", k, obs(), exp);
            end
            n_save += int'(pg_if.pg_ret_save);
            n_rest += int'(pg_if.pg_ret_restore);
            if (k == 2*N + 1) pg_if.pg_off_req = 1'b0;
            if (k == 3*N + 1) pg_if.pg_psw_ack = 1'b0;
            if (k == 3*N + 3) pg_if.pg_psw_ack = 1'b1;
        end
        n_cmp++;
        if (n_save != 1 || n_rest != 1) begin
            n_bad++;
            $display("FAIL reverse_pulses save=%0d restore=%0d exp=1/1", n_save, n_rest);
        end
    endtask

    task automatic test_ack_timeout();
        logic [7:0] exp;
        rst = 1'b1;
        pg_if.pg_off_req = 1'b0;
        pg_if.pg_psw_ack = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 1; k <= 20 + 3*N; k++) begin
            step();
            if (k <= 19)            exp = V_MID | ((k >= TMO) ? P_ERR : 8'h00);
            else if (k <= 19 + N)   exp = V_MID | P_ERR | ((k == 20) ? P_REST : 8'h00);
            else if (k <= 19 + 2*N) exp = V_ISO_REL | P_ERR;
            else if (k <= 19 + 3*N) exp = V_CLK_ON | P_ERR;
            else                    exp = V_ON;
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL ack_timeout k=%0d got=%b exp=%b", k, obs(), exp);
            end
            if (k == 19) pg_if.pg_psw_ack = 1'b1;
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp;
        pg_if.pg_off_req = 1'b1;
        for (int k = 1; k <= N + 2; k++) step();
        n_cmp++;
        if (obs() !== V_MID) begin
            n_bad++;
            $display("FAIL reset_mid_pre got=%b exp=%b", obs(), V_MID);
        end
        #2;
        rst = 1'b1;
        pg_if.pg_off_req = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== V_MID) begin
            n_bad++;
            $display("FAIL reset_mid_async got=%b exp=%b", obs(), V_MID);
        end
        step();
        rst = 1'b0;
        for (int k = 1; k <= 3*N + 1; k++) begin
            step();
            if (k <= N)        exp = V_MID | ((k == 1) ? P_REST : 8'h00);
            else if (k <= 2*N) exp = V_ISO_REL;
            else if (k <= 3*N) exp = V_CLK_ON;
            else               exp = V_ON;
            n_cmp++;
            if (obs() !== exp) begin
                n_bad++;
                $display("FAIL reset_mid_up k=%0d got=%b exp=%b", k, obs(), exp);
            end
        end
    endtask

    task automatic test_stress();
        logic prev_save = 1'b0;
        logic prev_rest = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            step();
            n_cmp++;
            if ((pg_if.pg_iso_n && !pg_if.pg_psw_en) || (pg_if.pg_clk_en && !pg_if.pg_iso_n)) begin
                n_bad++;
                $display("FAIL stress_invariant cyc=%0d got=%b", c, obs());
            end
            n_cmp++;
            if ((pg_if.pg_ret_save && prev_save) || (pg_if.pg_ret_restore && prev_rest)) begin
                n_bad++;
                $display("FAIL stress_pulse cyc=%0d save=%b restore=%b exp=single-cycle",
                         c, pg_if.pg_ret_save, pg_if.pg_ret_restore);
            end
            prev_save = pg_if.pg_ret_save;
            prev_rest = pg_if.pg_ret_restore;
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) pg_if.pg_off_req = ~pg_if.pg_off_req;
            if ($urandom_range(0, 3) == 0) pg_if.pg_psw_ack = pg_if.pg_psw_en;
        end
        rst = 1'b0;
    endtask

    initial begin
        pg_if.pg_off_req = 1'b0;
        pg_if.pg_psw_ack = 1'b1;
        test_reset();
        test_power_down();
        test_power_up();
        test_reverse_in_save();
        test_ack_timeout();
        test_reset_mid();
        test_stress();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/nv_pg_seq.md
# nv_pg_seq

Power-gating sequencer for one switchable NVDLA partition. It produces the `iso_n` enable that drives the always-on AND isolation clamps on the partition outputs (clamps to 0 when low). It also drives the domain clock enable, the retention save/restore pulses and the power-switch enable. It sits in the always-on domain next to the clamp cells and handshakes with the power-switch chain acknowledge.

## Interface
Parameters:
- STEP_DLY, 4: cycles spent in each timed step; legal range 1..255.
- ACK_TMO, 255: cycles waited for the switch acknowledge before the error flag is raised; legal range 1..65535.
- CNT_W, 16: counter width; must hold max(STEP_DLY, ACK_TMO).

Ports:
- nvdla_core_clk, in, 1: always-on clock.
- nvdla_core_rst, in, 1: reset; asynchronous, active-high.
- pg_off_req, in, 1: level request. 1 means the partition should be off; 0 means on.
- pg_psw_ack, in, 1: switch-chain acknowledge (1 = rail powered). Synchronized externally.
- pg_psw_en, out, 1: power-switch enable.
- pg_iso_n, out, 1: isolation enable to the clamp cells; 0 = clamped.
- pg_clk_en, out, 1: partition clock enable.
- pg_ret_save, out, 1: one-cycle retention save pulse.
- pg_ret_restore, out, 1: one-cycle retention restore pulse.
- pg_on, out, 1: partition fully on and released.
- pg_busy, out, 1: a sequence is in progress.
- pg_err, out, 1: acknowledge timeout seen in the current sequence.

## Operation
- All outputs are registered and decoded from the state register plus the counter.
- States and their outputs (psw_en / iso_n / clk_en):
  - ON: 1/1/1
  - CLK_OFF: 1/1/0
  - ISO: 1/0/0
  - SAVE: 1/0/0
  - PSW_OFF: 0/0/0
  - OFF: 0/0/0
  - PSW_ON: 1/0/0
  - RESTORE: 1/0/0
  - ISO_REL: 1/1/0
  - CLK_ON: 1/1/1
- Power-down path: ON with pg_off_req=1 goes to CLK_OFF, then ISO, then SAVE, then PSW_OFF. PSW_OFF goes to OFF once pg_psw_ack=0 is sampled.
- Power-up path: OFF with pg_off_req=0 goes to PSW_ON. PSW_ON goes to RESTORE once pg_psw_ack=1 is sampled. RESTORE then goes to ISO_REL, then CLK_ON, then ON.
- Timed states are CLK_OFF, ISO, SAVE, RESTORE, ISO_REL and CLK_ON. Each lasts exactly STEP_DLY cycles.
- pg_ret_save is high only in the first cycle of SAVE. pg_ret_restore is high only in the first cycle of RESTORE.
- pg_off_req is sampled only in ON and OFF; changes during a sequence are ignored.
  - If the request reverses mid-sequence, the current sequence completes.
  - The reverse sequence then starts on the first cycle after arrival in ON or OFF.
- Acknowledge timeout:
  - In PSW_OFF and PSW_ON, the counter counts cycles waited.
  - When ACK_TMO cycles elapse without the expected ack, pg_err is set and the FSM keeps waiting. There is no abort and outputs are unchanged.
  - The counter saturates.
  - pg_err clears on entry to ON or OFF.
- pg_busy is 1 in every state except ON and OFF. pg_on is 1 only in ON.
- Invariants the verifier checks every cycle:
  - pg_iso_n=1 implies pg_psw_en=1.
  - pg_clk_en=1 implies pg_iso_n=1.

## Timing
- Reset (asynchronous, immediate) enters PSW_ON. Reset values:
  - pg_psw_en=1, pg_iso_n=0, pg_clk_en=0
  - pg_ret_save=0, pg_ret_restore=0
  - pg_on=0, pg_busy=1, pg_err=0
- After reset the normal power-up completes, including the restore pulse.
- Reset asserted mid-sequence aborts that sequence and behaves as a cold reset.
- Down latency, with pg_off_req=1 sampled in ON at edge e0:
  - pg_clk_en falls after e0.
  - pg_iso_n falls after e0+N.
  - pg_ret_save is high for cycle e0+2N.
  - pg_psw_en falls after e0+3N.
  - With ack=0 first sampled at edge ea, OFF is entered after ea: pg_busy=0 and pg_err cleared.
- Up latency, with pg_off_req=0 sampled in OFF at e0 and ack=1 first sampled at ea:
  - pg_psw_en rises after e0.
  - pg_ret_restore is high for cycle ea.
  - pg_iso_n rises after ea+N.
  - pg_clk_en rises after ea+2N.
  - pg_on=1 and pg_busy=0 after ea+3N.
- pg_err rises on the cycle after the ACK_TMO-th wait cycle. The transition still occurs on the first ack match.

## Test plan
- Reset, ack held 1, STEP_DLY=4 -> restore pulse in cycle 1, iso_n=1 at cycle 5, clk_en=1 at cycle 9, pg_on=1 at cycle 13, pg_err=0 throughout.
- From ON, pulse pg_off_req to 1 and hold; ack drops 3 cycles after psw_en falls:
  - clk_en falls at +1, iso_n at +5, save pulse at +9, psw_en at +13.
  - OFF (busy=0) at +16.
- In SAVE, drop pg_off_req to 0 -> OFF is still reached, then PSW_ON starts the next cycle. Exactly one save and one restore pulse occur.
- ACK_TMO=8, ack stuck 0 during power-up -> pg_err=1 after 8 wait cycles and outputs unchanged. Raising ack at cycle 20 proceeds to ON, and pg_err clears on ON entry.
- Assert reset in ISO -> outputs take reset values the same cycle, with no clock edge needed. The power-up sequence follows.
- Random req/ack/reset stress across 10k cycles -> both invariants hold every cycle, and save/restore pulses are never longer than one cycle.
